// File: rtl/tile_burst_writer_if.sv
// Avalon-MM burst-write bundle between tile_burst_writer (master) and the interconnect (slave).
interface tile_burst_writer_if #(
    parameter int PIXEL_W      = 16,
    parameter int PIX_PER_WORD = 2,
    parameter int TILE_W       = 32
);
    localparam int BUS_W = PIXEL_W * PIX_PER_WORD;
    localparam int BE_W  = BUS_W / 8;
    localparam int BC_W  = $clog2(TILE_W / PIX_PER_WORD) + 1;

    logic [31:0]      master_address;
    logic             master_write;
    logic [BUS_W-1:0] master_writedata;
    logic [BE_W-1:0]  master_byteenable;
    logic [BC_W-1:0]  master_burstcount;
    logic             master_waitrequest;

    modport master (
        output master_address, master_write, master_writedata,
        output master_byteenable, master_burstcount,
        input  master_waitrequest
    );

    modport slave (
        input  master_address, master_write, master_writedata,
        input  master_byteenable, master_burstcount,
        output master_waitrequest
    );
endinterface

// File: rtl/tile_burst_writer.sv
// Drains a tile from tile RAM into a word FIFO and writes each row as one Avalon-MM burst.
// Optional colour keying via byteenables is enabled by defining TILE_WRITER_KEY_EN.
module tile_burst_writer #(
    parameter int PIXEL_W      = 16,
    parameter int PIX_PER_WORD = 2,
    parameter int TILE_W       = 32,
    parameter int TILE_H       = 32,
    parameter int FIFO_DEPTH   = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [31:0]                       addr_in,
    input  logic [15:0]                       stride_in,
    input  logic [PIXEL_W-1:0]                key_color,
    output logic                              reading,
    output logic                              flushed,
    output logic [$clog2(TILE_W*TILE_H)-1:0]  ram_addr,
    input  logic [PIXEL_W-1:0]                ram_data,
    tile_burst_writer_if.master               m
);
    localparam int BUS_W = PIXEL_W * PIX_PER_WORD;
    localparam int BE_W  = BUS_W / 8;
    localparam int PB    = PIXEL_W / 8;
    localparam int WPR   = TILE_W / PIX_PER_WORD;
    localparam int BC_W  = $clog2(WPR) + 1;
    localparam int AW    = $clog2(TILE_W * TILE_H);
    localparam int CW    = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int RW    = $clog2(TILE_H + 1);
    localparam int PCW   = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int BW    = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int PW    = $clog2(FIFO_DEPTH);
`ifdef TILE_WRITER_KEY_EN
    localparam int FW    = BUS_W + BE_W;
`else
    localparam int FW    = BUS_W;
`endif

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_FETCH} r_state_t;
    typedef enum logic       {W_IDLE, W_BURST}         w_state_t;

    r_state_t         r_state_q;
    logic [AW-1:0]    ram_addr_q;
    logic [CW-1:0]    col_q;
    logic [RW-1:0]    row_q;
    logic             fetch_q;
    logic [PCW-1:0]   pack_cnt_q;
    logic [BUS_W-1:0] pack_q;

    w_state_t         w_state_q;
    logic             wr_q;
    logic [31:0]      addr_q;
    logic [BUS_W-1:0] data_q;
    logic [31:0]      row_addr_q;
    logic [31:0]      stride_q;
    logic [RW-1:0]    rows_left_q;
    logic [BW-1:0]    beat_q;

    logic [FW-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q, rd_idx;
    logic [PW:0]      count_q;
    logic [PW+1:0]    free_space;

    logic             start_ok, push, pop, last_beat, burst_go, head_load;
    logic [BUS_W-1:0] word_shift;
    logic [FW-1:0]    fifo_din;

    assign flushed  = (r_state_q == R_IDLE) && !fetch_q && (w_state_q == W_IDLE) && (count_q == '0);
    assign reading  = (r_state_q != R_IDLE) || fetch_q;
    assign ram_addr = ram_addr_q;
    assign start_ok = start && flushed;

    // New pixel enters at the top so the lowest-addressed pixel ends up in the LSBs.
    assign word_shift = (pack_q >> PIXEL_W) | (BUS_W'(ram_data) << (BUS_W - PIXEL_W));
    assign push       = fetch_q && (pack_cnt_q == PCW'(PIX_PER_WORD - 1));
    assign pop        = (w_state_q == W_BURST) && !m.master_waitrequest;
    assign last_beat  = (beat_q == BW'(WPR - 1));
    assign burst_go   = (w_state_q == W_IDLE) && (count_q >= (PW+1)'(WPR)) && (rows_left_q != '0);
    assign head_load  = burst_go || (pop && !last_beat);
    assign rd_idx     = (w_state_q == W_BURST) ? rd_ptr_q + 1'b1 : rd_ptr_q;

    // Space check counts this cycle's push (the previous row's trailing word) and pop.
    assign free_space = (PW+2)'(FIFO_DEPTH) - (PW+2)'(count_q) + (PW+2)'(pop) - (PW+2)'(push);

    assign m.master_address    = addr_q;
    assign m.master_write      = wr_q;
    assign m.master_writedata  = data_q;
    assign m.master_burstcount = BC_W'(WPR);

`ifdef TILE_WRITER_KEY_EN
    logic [PIXEL_W-1:0] key_q;
    logic [BE_W-1:0]    be_pack_q, be_shift, be_q;
    logic               key_hit;

    assign key_hit  = (ram_data == key_q);
    assign be_shift = (be_pack_q >> PB) | (BE_W'({PB{~key_hit}}) << (BE_W - PB));
    assign fifo_din = {be_shift, word_shift};
    assign m.master_byteenable = be_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q     <= '0;
            be_pack_q <= '1;
            be_q      <= '1;
        end else begin
            if (start_ok)  key_q     <= key_color;
            if (fetch_q)   be_pack_q <= be_shift;
            if (head_load) be_q      <= fifo_mem[rd_idx][FW-1:BUS_W];
        end
    end
`else
    logic unused_key;
    assign unused_key = ^key_color;
    assign fifo_din   = word_shift;
    assign m.master_byteenable = {BE_W{1'b1}};
`endif

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= fifo_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q  <= R_IDLE;
            ram_addr_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            fetch_q    <= 1'b0;
            pack_cnt_q <= '0;
            pack_q     <= '0;
        end else begin
            fetch_q <= 1'b0;
            if (fetch_q) begin
                pack_q     <= word_shift;
                pack_cnt_q <= push ? '0 : pack_cnt_q + 1'b1;
            end
            case (r_state_q)
                R_IDLE: begin
                    if (start_ok) begin
                        ram_addr_q <= '0;
                        col_q      <= '0;
                        row_q      <= '0;
                        r_state_q  <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (free_space >= (PW+2)'(WPR)) r_state_q <= R_FETCH;
                end
                R_FETCH: begin
                    fetch_q    <= 1'b1;
                    ram_addr_q <= ram_addr_q + 1'b1;
                    if (col_q == CW'(TILE_W - 1)) begin
                        col_q     <= '0;
                        row_q     <= row_q + 1'b1;
                        r_state_q <= (row_q == RW'(TILE_H - 1)) ? R_IDLE : R_WAIT;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q   <= W_IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            row_addr_q  <= '0;
            stride_q    <= '0;
            rows_left_q <= '0;
            beat_q      <= '0;
        end else begin
            if (start_ok) begin
                row_addr_q  <= addr_in;
                stride_q    <= 32'(stride_in);
                rows_left_q <= RW'(TILE_H);
            end
            if (head_load) data_q <= fifo_mem[rd_idx][BUS_W-1:0];
            case (w_state_q)
                W_IDLE: begin
                    if (burst_go) begin
                        w_state_q <= W_BURST;
                        wr_q      <= 1'b1;
                        addr_q    <= row_addr_q & ~32'(BE_W - 1);
                        beat_q    <= '0;
                    end
                end
                W_BURST: begin
                    if (pop) begin
                        if (last_beat) begin
                            w_state_q   <= W_IDLE;
                            wr_q        <= 1'b0;
                            row_addr_q  <= row_addr_q + stride_q;
                            rows_left_q <= rows_left_q - 1'b1;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tile_burst_writer.sv
// Self-checking bench for tile_burst_writer: beat-level reference model of each tile plus directed corner cases.
module tb_tile_burst_writer;
    localparam int TILE_W = 32;
    localparam int TILE_H = 32;
    localparam int WPR    = 16;
    localparam int NBEATS = WPR * TILE_H;
`ifdef TILE_WRITER_KEY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] addr_in = '0;
    logic [15:0] stride_in = '0;
    logic [15:0] key_color = '0;
    logic        reading, flushed;
    logic [9:0]  ram_addr;
    logic [15:0] ram_data;

    tile_burst_writer_if #(.PIXEL_W(16), .PIX_PER_WORD(2), .TILE_W(TILE_W)) bus ();

    tile_burst_writer #(
        .PIXEL_W(16), .PIX_PER_WORD(2), .TILE_W(TILE_W), .TILE_H(TILE_H), .FIFO_DEPTH(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .addr_in(addr_in), .stride_in(stride_in),
        .key_color(key_color), .reading(reading), .flushed(flushed), .ram_addr(ram_addr),
        .ram_data(ram_data), .m(bus)
    );

    always #5 clk = ~clk;

    logic [15:0] ram [1024];
    always @(posedge clk) ram_data <= ram[ram_addr];

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] q_addr [$];
    logic [31:0] q_data [$];
    logic [3:0]  q_be   [$];
    longint last_beat_cyc = 0;
    int stall_chk = 0, stall_bad = 0;
    bit rand_wait = 1'b0;
    int n_chk = 0, n_pass = 0;

    initial begin
        bus.master_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.master_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Collects accepted beats and notes any output change during a stall.
    initial begin : monitor
        logic prev_stall;
        logic [31:0] pa, pd;
        logic [3:0] pb;
        prev_stall = 1'b0; pa = '0; pd = '0; pb = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.master_write) begin
                if (prev_stall) begin
                    stall_chk++;
                    if (bus.master_address !== pa || bus.master_writedata !== pd ||
                        bus.master_byteenable !== pb || bus.master_burstcount !== 5'd16)
                        stall_bad++;
                end
                if (!bus.master_waitrequest) begin
                    q_addr.push_back(bus.master_address);
                    q_data.push_back(bus.master_writedata);
                    q_be.push_back(bus.master_byteenable);
                    last_beat_cyc = cyc;
                end
                prev_stall = bus.master_waitrequest;
                pa = bus.master_address;
                pd = bus.master_writedata;
                pb = bus.master_byteenable;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic pulse(input logic [31:0] a, input logic [15:0] s, input logic [15:0] k);
        @(negedge clk);
        addr_in = a; stride_in = s; key_color = k; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_start(input logic [31:0] a, input logic [15:0] s, input logic [15:0] k);
        q_addr.delete(); q_data.delete(); q_be.delete();
        pulse(a, s, k);
    endtask

    task automatic wait_flushed(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!flushed && n < 5000);
        chk({tag, "_flush_timeout"}, 64'(flushed), 64'd1);
        chk({tag, "_flush_latency"}, 64'(cyc - last_beat_cyc), 64'd1);
    endtask

    task automatic check_tile(input string tag, input logic [31:0] a, input logic [15:0] s,
                              input logic [15:0] key);
        chk({tag, "_nbeats"}, 64'(q_addr.size()), 64'(NBEATS));
        for (int i = 0; i < NBEATS && i < q_addr.size(); i++) begin
            int r, k;
            logic [15:0] p0, p1;
            logic [31:0] ea;
            logic [3:0]  eb;
            r  = i / WPR;
            k  = i % WPR;
            p0 = ram[r * TILE_W + 2 * k];
            p1 = ram[r * TILE_W + 2 * k + 1];
            ea = (a + 32'(r) * 32'(s)) & 32'hFFFF_FFFC;
            eb = 4'hF;
            if (KEY_EN && p0 == key) eb[1:0] = 2'b00;
            if (KEY_EN && p1 == key) eb[3:2] = 2'b00;
            chk($sformatf("%s_addr[%0d]", tag, i), 64'(q_addr[i]), 64'(ea));
            chk($sformatf("%s_data[%0d]", tag, i), 64'(q_data[i]), 64'({p1, p0}));
            chk($sformatf("%s_be[%0d]", tag, i), 64'(q_be[i]), 64'(eb));
        end
        $display("tile %s: base %08h stride %0d key %04h beats %0d", tag, a, s, key, q_addr.size());
    endtask

    initial begin
        int n;
        for (int i = 0; i < 1024; i++) ram[i] = 16'(i);

        // Reset values, both while held and just after release.
        repeat (3) @(negedge clk);
        chk("rst_reading", 64'(reading), 64'd0);
        chk("rst_flushed", 64'(flushed), 64'd1);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_write", 64'(bus.master_write), 64'd0);
        chk("rst_address", 64'(bus.master_address), 64'd0);
        chk("rst_writedata", 64'(bus.master_writedata), 64'd0);
        chk("rst_byteenable", 64'(bus.master_byteenable), 64'hF);
        chk("rst_burstcount", 64'(bus.master_burstcount), 64'd16);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_flushed", 64'(flushed), 64'd1);

        // A: ramp data, no waitrequest, start-to-fetch latency.
        run_start(32'h1000_0000, 16'd1280, 16'h0000);
        chk("A_lat_reading", 64'(reading), 64'd1);
        @(negedge clk);
        @(negedge clk);
        chk("A_lat_ram_addr", 64'(ram_addr), 64'd1);
        wait_flushed("A");
        check_tile("A", 32'h1000_0000, 16'd1280, 16'h0000);

        // B: random pixels, random waitrequest.
        for (int i = 0; i < 1024; i++) ram[i] = 16'($urandom);
        rand_wait = 1'b1;
        run_start(32'h1000_0000, 16'd1280, ram[37]);
        wait_flushed("B");
        rand_wait = 1'b0;
        check_tile("B", 32'h1000_0000, 16'd1280, ram[37]);
        chk("B_stall_seen", 64'(stall_chk > 0), 64'd1);
        chk("B_stall_stable", 64'(stall_bad), 64'd0);

        // C: starts while reading and mid-burst are ignored.
        for (int i = 0; i < 1024; i++) ram[i] = 16'(i);
        run_start(32'h2000_0000, 16'd640, 16'h0000);
        repeat (5) @(negedge clk);
        chk("C_reading", 64'(reading), 64'd1);
        pulse(32'hDEAD_0000, 16'd64, 16'h0000);
        n = 0;
        while (!(bus.master_write && !reading) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("C_midburst_found", 64'(bus.master_write && !reading), 64'd1);
        pulse(32'hBEEF_0000, 16'd64, 16'h0000);
        wait_flushed("C");
        check_tile("C", 32'h2000_0000, 16'd640, 16'h0000);

        // D: address wrap.
        run_start(32'hFFFF_FC00, 16'h0400, 16'h0000);
        wait_flushed("D");
        check_tile("D", 32'hFFFF_FC00, 16'h0400, 16'h0000);
        chk("D_row0", 64'(q_addr[0]), 64'hFFFF_FC00);
        chk("D_row1", 64'(q_addr[16]), 64'h0000_0000);
        chk("D_row2", 64'(q_addr[32]), 64'h0000_0400);

        // E: colour key hitting pixel 5.
        run_start(32'h3000_0000, 16'd64, 16'h0005);
        wait_flushed("E");
        check_tile("E", 32'h3000_0000, 16'd64, 16'h0005);
        chk("E_row0_beat2_be", 64'(q_be[2]), KEY_EN ? 64'h3 : 64'hF);

        // F: reset mid-burst, then a clean tile.
        run_start(32'h4000_0000, 16'd1280, 16'h0000);
        n = 0;
        while (q_addr.size() < 3 * WPR + 5 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("F_reached_row3", 64'(q_addr.size()), 64'(3 * WPR + 5));
        rst_n = 1'b0;
        #1;
        chk("F_rst_write", 64'(bus.master_write), 64'd0);
        chk("F_rst_flushed", 64'(flushed), 64'd1);
        chk("F_rst_reading", 64'(reading), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) ram[i] = 16'($urandom);
        run_start(32'h4000_0000, 16'd1280, 16'h0000);
        wait_flushed("F");
        check_tile("F", 32'h4000_0000, 16'd1280, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
